// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the bus transaction arbiter.
// - arb_state_t : arbiter FSM states (2-bit encoding)
// - RW_READ / RW_WRITE : encoding of the per-requester direction bit
// - TXN_CNT_W : width of the served-transaction debug counter
package bus_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } arb_state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int TXN_CNT_W = 8;

endpackage

// File: rtl/bus_txn_arbiter_if.sv
// Bundle of requester-side and engine-side signals around bus_txn_arbiter.
// Ports (all carried in the interface):
//   req_i/rw_i           requester request level and direction
//   grant_o/done_o/valid_o  per-requester grant, completion and read-data pulses
//   err_o                watchdog abort pulse
//   tgt_req_o/tgt_rw_o   engine start pulse and held direction
//   tgt_done_i/tgt_dv_i  engine completion and data-valid pulses
//   txn_cnt_o            served-transaction counter
// Modports: slave = the arbiter itself, master = the surrounding logic
// (requesters plus engine) that drives the arbiter inputs.
interface bus_txn_arbiter_if
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]   req_i;
  logic [NUM_REQ-1:0]   rw_i;
  logic [NUM_REQ-1:0]   grant_o;
  logic [NUM_REQ-1:0]   done_o;
  logic [NUM_REQ-1:0]   valid_o;
  logic                 err_o;
  logic                 tgt_req_o;
  logic                 tgt_rw_o;
  logic                 tgt_done_i;
  logic                 tgt_dv_i;
  logic [TXN_CNT_W-1:0] txn_cnt_o;

  modport slave (
    input  req_i, rw_i, tgt_done_i, tgt_dv_i,
    output grant_o, done_o, valid_o, err_o, tgt_req_o, tgt_rw_o, txn_cnt_o
  );

  modport master (
    output req_i, rw_i, tgt_done_i, tgt_dv_i,
    input  grant_o, done_o, valid_o, err_o, tgt_req_o, tgt_rw_o, txn_cnt_o
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// Searches ptr_i+1, ptr_i+2, ... (modulo NUM_REQ) and returns the first
// requester whose req_i bit is set and whose mask_i bit is clear.
// Ports:
//   req_i   in  NUM_REQ  request vector
//   mask_i  in  NUM_REQ  requesters excluded from this search
//   ptr_i   in  IW       index of the most recently served requester
//   valid_o out 1        some unmasked request is active
//   win_o   out IW       winning requester index (0 when valid_o is low)
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] mask_i,
  input  logic [IW-1:0]      ptr_i,
  output logic               valid_o,
  output logic [IW-1:0]      win_o
);

  localparam logic [IW:0] NUM_REQ_W = (IW+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] req_eff_s;
  logic [IW:0]        cand_s;
  logic               hit_s;

  // First-match search in rotating order; one extra bit on cand_s holds ptr+i before the wrap.
  always_comb begin
    req_eff_s = req_i & ~mask_i;
    valid_o   = 1'b0;
    win_o     = '0;
    cand_s    = '0;
    hit_s     = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s  = {1'b0, ptr_i} + (IW+1)'(i);
      cand_s  = (cand_s >= NUM_REQ_W) ? (cand_s - NUM_REQ_W) : cand_s;
      hit_s   = !valid_o && req_eff_s[cand_s[IW-1:0]];
      win_o   = hit_s ? cand_s[IW-1:0] : win_o;
      valid_o = valid_o || hit_s;
    end
  end

endmodule

// File: rtl/bus_txn_arbiter.sv
// Round-robin arbiter sharing one bus transaction engine between NUM_REQ
// requesters, one transaction in flight at a time.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   bus_txn_arbiter_if.slave: requester req/rw in, grant/done/valid out,
//         engine start/direction out, engine done/data-valid in, err_o,
//         8-bit served-transaction counter
// Parameters: NUM_REQ (2..8), WDOG_CYCLES (watchdog timeout in S_WAIT).
// Build option: define ARB_WATCHDOG_EN to abort a transaction that sees no
// engine done for WDOG_CYCLES cycles; without it err_o is tied low and the
// arbiter waits for the engine indefinitely.
// Output timing: every output is a register. grant_o/tgt_req_o rise on the
// edge that leaves S_ISSUE; done_o/valid_o/err_o are set on the edge that
// enters S_RELEASE and cleared on the next edge.
module bus_txn_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WDOG_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  bus_txn_arbiter_if.slave  bus
);

  localparam int                 IW  = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 1) begin : g_bad_params
    $error("bus_txn_arbiter: unsupported NUM_REQ or WDOG_CYCLES");
  end

  arb_state_t           state_r;
  logic [IW-1:0]        ptr_r;
  logic [IW-1:0]        win_r;
  logic                 rw_r;
  logic [NUM_REQ-1:0]   grant_r;
  logic [NUM_REQ-1:0]   done_r;
  logic [NUM_REQ-1:0]   valid_r;
  logic                 tgt_req_r;
  logic                 tgt_rw_r;
  logic [TXN_CNT_W-1:0] cnt_r;

  logic [NUM_REQ-1:0]   win_onehot_s;
  logic [NUM_REQ-1:0]   mask_s;
  logic                 pick_valid_s;
  logic [IW-1:0]        pick_idx_s;

`ifdef ARB_WATCHDOG_EN
  localparam int            WDOG_W    = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0]    wdog_r;
  logic                 err_r;
`endif

  assign win_onehot_s = ONE << win_r;

  // In S_RELEASE the finishing requester still holds req_i (it drops it only
  // after seeing done_o), so it is excluded from the back-to-back pick.
  assign mask_s = (state_r == S_RELEASE) ? win_onehot_s : '0;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_picker (
    .req_i   (bus.req_i),
    .mask_i  (mask_s),
    .ptr_i   (ptr_r),
    .valid_o (pick_valid_s),
    .win_o   (pick_idx_s)
  );

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      ptr_r     <= IW'(NUM_REQ - 1);
      win_r     <= '0;
      rw_r      <= RW_WRITE;
      grant_r   <= '0;
      done_r    <= '0;
      valid_r   <= '0;
      tgt_req_r <= 1'b0;
      tgt_rw_r  <= 1'b0;
      cnt_r     <= '0;
`ifdef ARB_WATCHDOG_EN
      wdog_r    <= '0;
      err_r     <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low every cycle.
      done_r    <= '0;
      valid_r   <= '0;
      tgt_req_r <= 1'b0;
`ifdef ARB_WATCHDOG_EN
      err_r     <= 1'b0;
`endif
      case (state_r)
        S_IDLE: begin
          if (pick_valid_s) begin
            win_r   <= pick_idx_s;
            rw_r    <= bus.rw_i[pick_idx_s];
            state_r <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          tgt_req_r <= 1'b1;
          tgt_rw_r  <= rw_r;
          grant_r   <= win_onehot_s;
`ifdef ARB_WATCHDOG_EN
          wdog_r    <= '0;
`endif
          state_r   <= S_WAIT;
        end

        S_WAIT: begin
          if (bus.tgt_done_i) begin
            done_r   <= win_onehot_s;
            valid_r  <= win_onehot_s & {NUM_REQ{bus.tgt_dv_i && (rw_r == RW_READ)}};
            grant_r  <= '0;
            tgt_rw_r <= 1'b0;
            ptr_r    <= win_r;
            cnt_r    <= cnt_r + TXN_CNT_W'(1);
            state_r  <= S_RELEASE;
          end
`ifdef ARB_WATCHDOG_EN
          else if (wdog_r == WDOG_LAST) begin
            // Abort: the winner is released with an error, nothing is counted.
            done_r   <= win_onehot_s;
            err_r    <= 1'b1;
            grant_r  <= '0;
            tgt_rw_r <= 1'b0;
            ptr_r    <= win_r;
            state_r  <= S_RELEASE;
          end else begin
            wdog_r   <= wdog_r + WDOG_W'(1);
          end
`endif
        end

        S_RELEASE: begin
          if (pick_valid_s) begin
            win_r   <= pick_idx_s;
            rw_r    <= bus.rw_i[pick_idx_s];
            state_r <= S_ISSUE;
          end else begin
            state_r <= S_IDLE;
          end
        end

        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.grant_o   = grant_r;
  assign bus.done_o    = done_r;
  assign bus.valid_o   = valid_r;
  assign bus.tgt_req_o = tgt_req_r;
  assign bus.tgt_rw_o  = tgt_rw_r;
  assign bus.txn_cnt_o = cnt_r;
`ifdef ARB_WATCHDOG_EN
  assign bus.err_o     = err_r;
`else
  assign bus.err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_bus_txn_arbiter.sv
// Directed self-checking bench for bus_txn_arbiter (NUM_REQ=4, WDOG_CYCLES=16).
// Inputs are driven and outputs sampled just after the falling clock edge.
// A small engine model pulses tgt_done_i eng_lat cycles after it sees
// tgt_req_o (eng_lat=0: engine never answers). Requesters optionally drop
// their request on seeing their own done_o.
module tb_bus_txn_arbiter;
  import bus_arb_pkg::*;

  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bus_txn_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  bus_txn_arbiter #(
    .NUM_REQ     (NREQ),
    .WDOG_CYCLES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [NREQ-1:0] req_s   = '0;
  logic [NREQ-1:0] rw_s    = '0;
  bit              auto_drop = 1'b1;
  bit              inj_done  = 1'b0;
  bit              eng_dv    = 1'b0;
  int              eng_lat   = 3;
  int              eng_cd    = 0;
  int              cyc       = 0;

  int order_q[$];
  int done_q[$];
  int treq_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [NREQ-1:0] r, input logic [NREQ-1:0] w);
    req_s    = r;
    rw_s     = w;
    bus.req_i = r;
    bus.rw_i  = w;
  endtask

  // One clock: observe outputs, run requester/engine models, drive inputs.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.tgt_req_o) treq_q.push_back(cyc);
    if (|bus.done_o) begin
      done_q.push_back(cyc);
      for (int i = 0; i < NREQ; i++) if (bus.done_o[i]) order_q.push_back(i);
      if (auto_drop) req_s = req_s & ~bus.done_o;
    end
    bus.tgt_done_i = 1'b0;
    bus.tgt_dv_i   = 1'b0;
    if (rst) begin
      eng_cd = 0;
    end else begin
      if (eng_cd > 0) begin
        eng_cd--;
        if (eng_cd == 0) begin
          bus.tgt_done_i = 1'b1;
          bus.tgt_dv_i   = eng_dv;
        end
      end
      if (bus.tgt_req_o && eng_lat > 0) eng_cd = eng_lat;
    end
    if (inj_done) begin
      bus.tgt_done_i = 1'b1;
      inj_done       = 1'b0;
    end
    bus.req_i = req_s;
    bus.rw_i  = rw_s;
  endtask

  task automatic wait_dones(input string tag, input int n, input int budget);
    int start;
    int k;
    start = order_q.size();
    k = 0;
    while ((order_q.size() - start) < n && k < budget) begin
      step();
      k++;
    end
    check(tag, order_q.size() - start, n);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got=hang exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cnt0;
    int cnt1;
    int cnt2;
    int cnt3;
    int bad_seq;

    bus.req_i      = '0;
    bus.rw_i       = '0;
    bus.tgt_done_i = 1'b0;
    bus.tgt_dv_i   = 1'b0;

    // Reset
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("rst_grant",  bus.grant_o,   4'b0000);
    check("rst_done",   bus.done_o,    4'b0000);
    check("rst_valid",  bus.valid_o,   4'b0000);
    check("rst_tgtreq", bus.tgt_req_o, 1'b0);
    check("rst_tgtrw",  bus.tgt_rw_o,  1'b0);
    check("rst_err",    bus.err_o,     1'b0);
    check("rst_cnt",    bus.txn_cnt_o, 8'd0);

    // Single WRITE from requester 0; requester drops req mid-transaction
    auto_drop = 1'b1; eng_lat = 3; eng_dv = 1'b0;
    set_req(4'b0001, 4'b0000);
    step();
    check("w_grant_1cyc",  bus.grant_o,   4'b0000);
    check("w_tgtreq_1cyc", bus.tgt_req_o, 1'b0);
    step();
    check("w_grant",  bus.grant_o,   4'b0001);
    check("w_tgtreq", bus.tgt_req_o, 1'b1);
    check("w_tgtrw",  bus.tgt_rw_o,  1'b0);
    step();
    check("w_tgtreq_pulse", bus.tgt_req_o, 1'b0);
    check("w_grant_held",   bus.grant_o,   4'b0001);
    set_req(4'b0000, 4'b0000);
    step(); step();
    check("w_done_early", bus.done_o, 4'b0000);
    step();
    check("w_done",  bus.done_o,    4'b0001);
    check("w_valid", bus.valid_o,   4'b0000);
    check("w_cnt",   bus.txn_cnt_o, 8'd1);
    check("w_grant_rel", bus.grant_o, 4'b0000);
    step();
    check("w_done_pulse", bus.done_o, 4'b0000);
    check("w_err", bus.err_o, 1'b0);

    // Single READ with data valid; rw_i flips after latch and is ignored
    eng_lat = 2; eng_dv = 1'b1;
    set_req(4'b0100, 4'b0100);
    step();
    set_req(4'b0100, 4'b0000);
    step();
    check("r_grant", bus.grant_o,  4'b0100);
    check("r_tgtrw", bus.tgt_rw_o, 1'b1);
    step();
    check("r_tgtrw_held", bus.tgt_rw_o, 1'b1);
    step();
    step();
    check("r_done",  bus.done_o,    4'b0100);
    check("r_valid", bus.valid_o,   4'b0100);
    check("r_cnt",   bus.txn_cnt_o, 8'd2);
    step();
    check("r_done_pulse",  bus.done_o,  4'b0000);
    check("r_valid_pulse", bus.valid_o, 4'b0000);

    // Stray engine done while idle is ignored
    inj_done = 1'b1;
    step(); step();
    check("stray_done", bus.done_o,    4'b0000);
    check("stray_cnt",  bus.txn_cnt_o, 8'd2);

    // Reset in S_WAIT: no done, everything cleared, pointer back to reset value
    eng_lat = 0;
    set_req(4'b0010, 4'b0000);
    repeat (3) step();
    check("rw_grant_wait", bus.grant_o, 4'b0010);
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(4'b0000, 4'b0000);
    check("rw_grant", bus.grant_o,   4'b0000);
    check("rw_tgtrw", bus.tgt_rw_o,  1'b0);
    check("rw_cnt",   bus.txn_cnt_o, 8'd0);
    check("rw_done",  bus.done_o,    4'b0000);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rw_no_done", bus.done_o, 4'b0000);
    end
    eng_lat = 1;
    order_q.delete();
    set_req(4'b1000, 4'b0000);
    step(); step();
    check("rw_fresh_grant", bus.grant_o, 4'b1000);
    wait_dones("rw_fresh_wait", 1, 20);
    check("rw_fresh_who", order_q[0], 3);
    check("rw_fresh_cnt", bus.txn_cnt_o, 8'd1);
    step(); step();

    // Round-robin with all four requesting; back-to-back issue from release
    order_q.delete(); done_q.delete(); treq_q.delete();
    eng_lat = 2; eng_dv = 1'b0;
    set_req(4'b1111, 4'b0000);
    wait_dones("rr_wait", 4, 100);
    check("rr_ord0", order_q[0], 0);
    check("rr_ord1", order_q[1], 1);
    check("rr_ord2", order_q[2], 2);
    check("rr_ord3", order_q[3], 3);
    check("rr_cnt",  bus.txn_cnt_o, 8'd5);
    check("rr_b2b_gap", treq_q[1] - done_q[0], 2);
    step(); step(); step();

    // After serving 3, requesters 1 and 3: 1 wins first
    order_q.delete();
    set_req(4'b1010, 4'b0000);
    wait_dones("fw_wait", 2, 60);
    check("fw_first",  order_q[0], 1);
    check("fw_second", order_q[1], 3);
    check("fw_cnt", bus.txn_cnt_o, 8'd7);
    step(); step(); step();

    // Fairness under continuous load, then counter wrap 255 -> 0
    order_q.delete();
    auto_drop = 1'b0; eng_lat = 1; eng_dv = 1'b1;
    set_req(4'b1111, 4'b1111);
    wait_dones("wrap_wait", 248, 3000);
    cnt0 = 0; cnt1 = 0; cnt2 = 0; cnt3 = 0; bad_seq = 0;
    for (int i = 0; i < order_q.size(); i++) begin
      case (order_q[i])
        0: cnt0++;
        1: cnt1++;
        2: cnt2++;
        default: cnt3++;
      endcase
      if (i > 0 && order_q[i] != ((order_q[i-1] + 1) % NREQ)) bad_seq++;
    end
    check("fair_first", order_q[0], 0);
    check("fair_n0", cnt0, 62);
    check("fair_n3", cnt3, 62);
    check("fair_seq", bad_seq, 0);
    check("fair_cnt255", bus.txn_cnt_o, 8'd255);
    wait_dones("wrap_last", 1, 20);
    check("wrap_cnt0", bus.txn_cnt_o, 8'd0);
    check("wrap_valid", bus.valid_o, 4'b0001);
    set_req(4'b0000, 4'b0000);
    auto_drop = 1'b1;
    repeat (3) step();
    check("wrap_idle_grant", bus.grant_o, 4'b0000);
    check("wrap_idle_cnt", bus.txn_cnt_o, 8'd0);

`ifdef ARB_WATCHDOG_EN
    // Engine never answers: abort 16 cycles after S_WAIT entry
    eng_lat = 0;
    set_req(4'b0100, 4'b0100);
    repeat (17) step();
    check("wd_err_early",  bus.err_o,  1'b0);
    check("wd_done_early", bus.done_o, 4'b0000);
    step();
    check("wd_err",   bus.err_o,     1'b1);
    check("wd_done",  bus.done_o,    4'b0100);
    check("wd_valid", bus.valid_o,   4'b0000);
    check("wd_cnt",   bus.txn_cnt_o, 8'd0);
    step();
    check("wd_err_pulse", bus.err_o, 1'b0);
`else
    // Engine never answers: without the watchdog the arbiter keeps waiting
    eng_lat = 0;
    set_req(4'b0100, 4'b0100);
    repeat (30) step();
    check("nowd_err",   bus.err_o,   1'b0);
    check("nowd_done",  bus.done_o,  4'b0000);
    check("nowd_grant", bus.grant_o, 4'b0100);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_txn_arbiter.md
Name: bus_txn_arbiter

Overview:
- Shares one bus transaction engine between NUM_REQ requesters. The engine has a single-cycle req/rw start, a one-cycle done pulse and a one-cycle data_valid pulse.
- Round-robin arbitration; one transaction in flight at a time.
- Holds the winner's rw stable for the whole transaction; routes done/data_valid back to the winner.
- Sits between requester logic and the engine's start/completion pins; 8-bit served-transaction counter for debug.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WDOG_CYCLES, 16, cycles waited in S_WAIT before watchdog abort (used only with ARB_WATCHDOG_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_i  in  NUM_REQ  per-requester request; level, held until own done_o
- rw_i  in  NUM_REQ  per-requester direction, 1=READ 0=WRITE; valid while req_i high
- grant_o  out  NUM_REQ  one-hot grant, high from S_ISSUE until S_RELEASE
- done_o  out  NUM_REQ  one-cycle completion pulse to the winner
- valid_o  out  NUM_REQ  one-cycle pulse with done_o when a READ returned data_valid
- err_o  out  1  one-cycle watchdog abort pulse (0 without ARB_WATCHDOG_EN)
- tgt_req_o  out  1  engine start, one cycle
- tgt_rw_o  out  1  engine direction, held S_ISSUE..S_WAIT exit
- tgt_done_i  in  1  engine done pulse
- tgt_dv_i  in  1  engine data_valid pulse, coincident with tgt_done_i
- txn_cnt_o  out  8  completed transactions, wraps 255->0

Behaviour:
- Reset: state=S_IDLE; all outputs 0; txn_cnt_o=0; rr pointer=NUM_REQ-1, so requester 0 wins first.
- All outputs registered.
- Arbitration search order: ptr+1, ptr+2, ..., wrapping modulo NUM_REQ. The first active req_i wins.
- S_IDLE: if any req_i, latch winner index w and rw_i[w], go S_ISSUE. Otherwise stay.
- S_ISSUE (1 cycle): tgt_req_o=1, tgt_rw_o=latched rw, grant_o[w]=1. Go S_WAIT.
- S_WAIT: tgt_req_o=0; grant and tgt_rw_o held.
  - On tgt_done_i: capture tgt_dv_i, go S_RELEASE.
- S_RELEASE (1 cycle):
  - done_o[w]=1; valid_o[w]=captured dv AND latched rw.
  - grant_o=0; ptr=w; txn_cnt_o+=1.
  - If any req_i other than req_i[w] is active, arbitrate (winner ≠ w) and go S_ISSUE. Otherwise go S_IDLE.
  - req_i[w] is masked here because the requester drops it only after seeing done_o.
- Latency: req_i rise in idle -> tgt_req_o 2 cycles later (grant_o/tgt_req_o rise together). tgt_done_i -> done_o next cycle.
- Winner drops req_i mid-transaction: the engine cannot abort, so the transaction completes and done_o still pulses.
- rw_i changes after latch: ignored.
- tgt_done_i outside S_WAIT: ignored.
- New req_i during a transaction: queued by level; served in RR order.
- rst mid-transaction: immediate return to reset state, no done_o. The engine shares the same reset.
- Fairness: with all NUM_REQ requests continuously active, each is served once per NUM_REQ transactions.

Optional Feature:
- Macro ARB_WATCHDOG_EN.
  - Defined: a counter clears on S_WAIT entry. If WDOG_CYCLES elapse without tgt_done_i, go S_RELEASE with done_o[w]=1, valid_o=0, err_o=1 for that cycle; txn_cnt_o not incremented.
  - Undefined: S_WAIT waits indefinitely; err_o tied 0; no counter logic.

Decomposition:
- Package bus_arb_pkg:
  - state enum S_IDLE/S_ISSUE/S_WAIT/S_RELEASE, 2-bit
  - RW_READ=1, RW_WRITE=0
  - TXN_CNT_W=8
- Sub-module rr_picker (combinational):
  - inputs: req vector, mask vector, pointer
  - outputs: valid, winner index
  - instantiated once.

Test Plan:
- Single WRITE: req_i=4'b0001, rw=0, engine model done 3 cycles after tgt_req_o -> grant_o=0001 two cycles after req, tgt_rw_o=0, done_o[0] one cycle after tgt_done_i, valid_o=0, txn_cnt_o=1.
- Single READ with dv: req_i[2]=1, rw_i[2]=1, tgt_dv_i=1 with done -> done_o[2] and valid_o[2] same cycle, each 1 cycle wide.
- Round-robin: req_i=4'b1111 held (each drops after own done) -> service order 0,1,2,3. Back-to-back ISSUE directly from RELEASE; txn_cnt_o=4.
- Fairness/wrap: after serving 3, assert req 3 and 1 -> 1 wins before 3. Run 256 transactions -> txn_cnt_o wraps to 0.
- Reset mid-S_WAIT: rst pulse -> all outputs 0 next cycle, no done_o. Next req_i=4'b1000 arbitrated as fresh (pointer reset).
- ARB_WATCHDOG_EN, WDOG_CYCLES=16, engine never signals done -> err_o and done_o[w] pulse 16 cycles after S_WAIT entry, valid_o=0, txn_cnt_o unchanged.
